// File: rtl/pixel_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sdram_writer
// Function : Pairs camera FIFO bytes into RGB565 words and writes them to
//            consecutive SDRAM word addresses across a ring of frame slots.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sdram_writer #(
  parameter int FRAME_PIXELS = 65536,
  parameter int NUM_FRAMES   = 5,
  parameter int ADDR_WIDTH   = 22,
  parameter int BASE_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  input  logic                  wr_ack,
  output logic                  frame_done,
  output logic [2:0]            frame_index,
  output logic                  busy
);

  localparam int c_CNT_W = $clog2(FRAME_PIXELS);

  localparam logic [2:0] c_RD_HI  = 3'd0;
  localparam logic [2:0] c_CAP_HI = 3'd1;
  localparam logic [2:0] c_RD_LO  = 3'd2;
  localparam logic [2:0] c_CAP_LO = 3'd3;
  localparam logic [2:0] c_WRITE  = 3'd4;

  localparam logic [c_CNT_W-1:0]    c_LAST_PIX     = c_CNT_W'(FRAME_PIXELS - 1);
  localparam logic [2:0]            c_LAST_FRAME   = 3'(NUM_FRAMES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_BASE         = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_FRAME_STRIDE = ADDR_WIDTH'(FRAME_PIXELS);

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [7:0]            r_pixel_hi;
  logic                  r_wr_req;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_frame_done;
  logic [2:0]            r_frame_index;
  logic [c_CNT_W-1:0]    r_pixel_cnt;
  logic                  w_rd_en;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] w_pix_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_RD_HI;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = c_RD_HI;
    end else begin
      case (r_state)
        c_RD_HI:  if (!fifo_empty) w_next_state = c_CAP_HI;
        c_CAP_HI: w_next_state = c_RD_LO;
        c_RD_LO:  if (!fifo_empty) w_next_state = c_CAP_LO;
        c_CAP_LO: w_next_state = c_WRITE;
        c_WRITE:  if (wr_ack) w_next_state = c_RD_HI;
        default:  w_next_state = c_RD_HI;
      endcase
    end
  end

  // Pop only from a read state; reset and clear both hold the FIFO still.
  always_comb begin
    w_rd_en = 1'b0;
    if (rst_n && !clear && !fifo_empty &&
        ((r_state == c_RD_HI) || (r_state == c_RD_LO))) begin
      w_rd_en = 1'b1;
    end
    w_busy = (r_state != c_RD_HI);
  end

  assign w_pix_addr = c_BASE
                    + ADDR_WIDTH'(r_frame_index) * c_FRAME_STRIDE
                    + ADDR_WIDTH'(r_pixel_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_hi    <= 8'd0;
      r_wr_req      <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 16'd0;
      r_frame_done  <= 1'b0;
      r_frame_index <= 3'd0;
      r_pixel_cnt   <= '0;
    end else if (clear) begin
      r_wr_req      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_index <= 3'd0;
      r_pixel_cnt   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_CAP_HI: r_pixel_hi <= fifo_dout;
        c_CAP_LO: begin
          r_wr_data <= {r_pixel_hi, fifo_dout};
          r_wr_addr <= w_pix_addr;
          r_wr_req  <= 1'b1;
        end
        c_WRITE: begin
          if (wr_ack) begin
            r_wr_req <= 1'b0;
            if (r_pixel_cnt == c_LAST_PIX) begin
              r_pixel_cnt   <= '0;
              r_frame_done  <= 1'b1;
              r_frame_index <= (r_frame_index == c_LAST_FRAME) ? 3'd0 : r_frame_index + 3'd1;
            end else begin
              r_pixel_cnt <= r_pixel_cnt + c_CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd_en  = w_rd_en;
  assign busy        = w_busy;
  assign wr_req      = r_wr_req;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_done  = r_frame_done;
  assign frame_index = r_frame_index;

endmodule
`default_nettype wire

// File: tb/tb_pixel_sdram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sdram_writer
// Function : Randomised and directed bench for pixel_sdram_writer against a
//            pixel-stream reference model (FIFO model + write log).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sdram_writer;

  localparam int FP   = 4;
  localparam int NF   = 2;
  localparam int AW   = 22;
  localparam int BASE = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_dout = 8'd0;
  logic          fifo_rd_en;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ack = 1'b0;
  logic          frame_done;
  logic [2:0]    frame_index;
  logic          busy;

  pixel_sdram_writer #(
    .FRAME_PIXELS(FP), .NUM_FRAMES(NF), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .frame_done(frame_done), .frame_index(frame_index), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO contents, bytes popped toward the pixel in flight, observed writes
  logic [7:0]    byte_q[$];
  logic [7:0]    pend[$];
  logic [AW-1:0] wl_addr[$];
  logic [15:0]   wl_data[$];
  int            req_len_log[$];
  logic [2:0]    done_log[$];

  int stage, exp_cnt, exp_fidx, ack_wait, ack_max, req_run;
  bit exp_done, just_popped, pop_d, ack_d, clear_d;
  bit rand_mode, spurious, hold_empty, clear_on_ack, clear_now;
  logic [7:0]    pop_byte;
  logic [AW-1:0] obs_addr;
  logic [15:0]   obs_data;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr();
    return 32'(BASE + exp_fidx * FP + exp_cnt);
  endfunction

  task automatic model_reset();
    pend.delete();
    stage = 0; just_popped = 0; exp_cnt = 0; exp_fidx = 0; exp_done = 0; req_run = 0;
  endtask

  // One clock: update model for the edge just passed, check, drive next inputs.
  task automatic step();
    @(negedge clk);
    if (clear_d) begin
      model_reset();
    end else begin
      exp_done = 0;
      if (stage == 2 && ack_d) begin
        wl_addr.push_back(obs_addr);
        wl_data.push_back(obs_data);
        req_len_log.push_back(req_run);
        req_run = 0;
        pend.delete();
        stage = 0;
        if (exp_cnt == FP - 1) begin
          exp_cnt = 0; exp_done = 1;
          exp_fidx = (exp_fidx == NF - 1) ? 0 : exp_fidx + 1;
        end else begin
          exp_cnt++;
        end
      end else if (stage == 1) begin
        stage = 2;
        ack_wait = rand_mode ? $urandom_range(0, 3) : ack_max;
      end
      just_popped = pop_d;
      if (pop_d) begin
        pend.push_back(pop_byte);
        if (pend.size() == 2) stage = 1;
      end
    end

    check("busy", 32'(busy), 32'(pend.size() != 0));
    check("wr_req", 32'(wr_req), 32'(stage == 2));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    check("frame_index", 32'(frame_index), 32'(exp_fidx));
    if (stage == 2) begin
      check("wr_addr", 32'(wr_addr), exp_addr());
      check("wr_data", 32'(wr_data), 32'({pend[0], pend[1]}));
      req_run++;
    end
    if (frame_done) done_log.push_back(frame_index);

    fifo_dout = pop_d ? pop_byte : 8'($urandom);
    if (rand_mode) hold_empty = ($urandom_range(0, 2) == 0);
    fifo_empty = hold_empty || (byte_q.size() == 0);
    if (stage == 2) begin
      if (ack_wait == 0) wr_ack = 1'b1;
      else begin wr_ack = 1'b0; ack_wait--; end
    end else begin
      wr_ack = spurious && ($urandom_range(0, 3) == 0);
    end
    clear = 1'b0;
    if (clear_now) begin
      clear = 1'b1; clear_now = 0;
    end else if (clear_on_ack && stage == 2 && wr_ack && exp_cnt == FP - 1) begin
      clear = 1'b1; clear_on_ack = 0;
    end else if (rand_mode && $urandom_range(0, 149) == 0) begin
      clear = 1'b1;
    end
    #1;
    check("fifo_rd_en", 32'(fifo_rd_en),
          32'(!clear && !fifo_empty && stage == 0 && !just_popped));
    pop_d = fifo_rd_en; ack_d = wr_ack; clear_d = clear;
    obs_addr = wr_addr; obs_data = wr_data;
    if (pop_d) begin
      if (byte_q.size() > 0) pop_byte = byte_q.pop_front();
      else pop_byte = 8'h00;
    end
  endtask

  task automatic run_idle(input int limit, input string tag);
    int n = 0;
    while (!(byte_q.size() == 0 && pend.size() == 0 && !pop_d && stage == 0) && n < limit) begin
      if (byte_q.size() == 0 && pend.size() == 1 && !pop_d) byte_q.push_back(8'($urandom));
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(n < limit), 32'd1);
  endtask

  task automatic do_reset_check();
    fifo_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_index", 32'(frame_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    wr_ack = 1'b0; clear = 1'b0; fifo_empty = 1'b1;
    rst_n = 1'b1;
    model_reset();
    pop_d = 0; ack_d = 0; clear_d = 0;
  endtask

  initial begin
    logic [7:0] bytes[20];
    ack_max = 0; rand_mode = 0; spurious = 0; hold_empty = 0;
    clear_on_ack = 0; clear_now = 0; ack_wait = 0;
    model_reset();
    pop_d = 0; ack_d = 0; clear_d = 0;
    do_reset_check();

    // Byte pairing with immediate ack
    wl_addr.delete(); wl_data.delete();
    byte_q.push_back(8'hAB); byte_q.push_back(8'hCD);
    byte_q.push_back(8'h12); byte_q.push_back(8'h34);
    run_idle(60, "pairing");
    check("pair_count", 32'(wl_data.size()), 32'd2);
    if (wl_data.size() >= 2) begin
      check("pair0_data", 32'(wl_data[0]), 32'hABCD);
      check("pair0_addr", 32'(wl_addr[0]), 32'(BASE));
      check("pair1_data", 32'(wl_data[1]), 32'h1234);
      check("pair1_addr", 32'(wl_addr[1]), 32'(BASE + 1));
    end

    // Backpressure: ack held off for 10 cycles
    wl_data.delete(); req_len_log.delete(); ack_max = 10;
    byte_q.push_back(8'h11); byte_q.push_back(8'h22);
    byte_q.push_back(8'h33); byte_q.push_back(8'h44);
    run_idle(120, "backpressure");
    check("bp_count", 32'(req_len_log.size()), 32'd2);
    if (req_len_log.size() >= 2) begin
      check("bp_req_len0", 32'(req_len_log[0]), 32'd11);
      check("bp_req_len1", 32'(req_len_log[1]), 32'd11);
      check("bp_data1", 32'(wl_data[1]), 32'h3344);
    end

    // Asynchronous reset in the middle of a pending write
    ack_max = 40;
    byte_q.push_back(8'h77); byte_q.push_back(8'h88);
    for (int i = 0; i < 20 && stage != 2; i++) step();
    repeat (3) step();
    check("pre_rst_req", 32'(wr_req), 32'd1);
    check("pre_rst_fidx", 32'(frame_index), 32'd1);
    do_reset_check();
    ack_max = 0; wl_addr.delete(); wl_data.delete();
    byte_q.push_back(8'h5A); byte_q.push_back(8'hA5);
    run_idle(60, "post_reset");
    if (wl_addr.size() >= 1) begin
      check("post_rst_addr", 32'(wl_addr[0]), 32'(BASE));
      check("post_rst_data", 32'(wl_data[0]), 32'h5AA5);
    end else check("post_rst_count", 32'(wl_addr.size()), 32'd1);

    // FIFO underflow between the two bytes of a pixel
    wl_addr.delete(); wl_data.delete();
    byte_q.push_back(8'hC3);
    repeat (9) step();
    check("underflow_busy", 32'(busy), 32'd1);
    byte_q.push_back(8'h3C);
    run_idle(60, "underflow");
    if (wl_data.size() >= 1) begin
      check("underflow_data", 32'(wl_data[0]), 32'hC33C);
      check("underflow_addr", 32'(wl_addr[0]), 32'(BASE + 1));
    end else check("underflow_count", 32'(wl_data.size()), 32'd1);

    // clear coinciding with the ack of the last pixel of a slot
    clear_now = 1; step();
    wl_addr.delete(); wl_data.delete(); done_log.delete();
    clear_on_ack = 1;
    for (int i = 0; i < 8; i++) byte_q.push_back(8'(i + 1));
    run_idle(120, "clear_ack");
    check("clr_writes", 32'(wl_addr.size()), 32'd3);
    check("clr_no_done", 32'(done_log.size()), 32'd0);
    check("clr_fidx", 32'(frame_index), 32'd0);
    wl_addr.delete();
    byte_q.push_back(8'hE1); byte_q.push_back(8'hE2);
    run_idle(60, "after_clear");
    if (wl_addr.size() >= 1) check("clr_next_addr", 32'(wl_addr[0]), 32'(BASE));
    else check("clr_next_count", 32'(wl_addr.size()), 32'd1);

    // Frame wrap across two slots
    clear_now = 1; step();
    wl_addr.delete(); wl_data.delete(); done_log.delete();
    for (int i = 0; i < 20; i++) begin
      bytes[i] = 8'($urandom);
      byte_q.push_back(bytes[i]);
    end
    run_idle(400, "wrap");
    check("wrap_count", 32'(wl_addr.size()), 32'd10);
    if (wl_addr.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        check("wrap_addr", 32'(wl_addr[i]), 32'(BASE + (i % (FP * NF))));
        check("wrap_data", 32'(wl_data[i]), 32'({bytes[2*i], bytes[2*i+1]}));
      end
    end
    check("wrap_done_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() >= 2) begin
      check("wrap_done0_fidx", 32'(done_log[0]), 32'd1);
      check("wrap_done1_fidx", 32'(done_log[1]), 32'd0);
    end

    // Randomised traffic: empty gaps, ack delays, stray acks, random clears
    rand_mode = 1; spurious = 1;
    for (int i = 0; i < 2500; i++) begin
      if (byte_q.size() < 4 && $urandom_range(0, 1) == 1) byte_q.push_back(8'($urandom));
      step();
    end
    rand_mode = 0; spurious = 0; hold_empty = 0;
    run_idle(300, "random_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
